// File: rtl/max7219_frame_ctrl.sv
// MAX7219 8x8 display controller: runs the init sequence, then refreshes rows
// continuously through a 16-bit SPI word writer using a str/busy handshake.
module max7219_frame_ctrl #(
   parameter int unsigned BUSY_TO    = 4096,
   parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
   input  logic       sys_clk,
   input  logic       _rst,
   input  logic       start,
   input  logic [3:0] intensity,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       busy,
   output logic       str,
   output logic [7:0] IRreg,
   output logic [7:0] data,
   output logic       ready,
   output logic       frame_done,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, INIT, REFRESH, INTENS} top_t;
   typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO, GAP} cmd_t;

   localparam logic [12:0] TO_LAST = 13'(BUSY_TO - 1);

   top_t        top_q, top_d;
   cmd_t        cmd_q, cmd_d;
   logic [2:0]  init_idx_q, init_idx_d;
   logic [2:0]  row_q, row_d;
   logic [12:0] cnt_q, cnt_d;
   logic [3:0]  ilast_q, ilast_d;
   logic        str_q, str_d;
   logic [7:0]  irreg_q, irreg_d;
   logic [7:0]  data_q, data_d;
   logic        ready_q, ready_d;
   logic        fd_q, fd_d;
   logic        err_q, err_d;

   logic [7:0][7:0] fb_rows;
   logic [7:0]      cmd_addr;
   logic [7:0]      cmd_data;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_fb
         logic [7:0] row_buf_q;
         always_ff @(posedge sys_clk or negedge _rst) begin
            if (!_rst) begin
               row_buf_q <= '0;
            end else if (wr_en && (wr_row == 3'(gi))) begin
               row_buf_q <= wr_data;
            end
         end
         assign fb_rows[gi] = row_buf_q;
      end
   endgenerate

   // Address/data of the command the current top state wants to send next
   always_comb begin
      cmd_addr = 8'h00;
      cmd_data = 8'h00;
      case (top_q)
         INIT: begin
            case (init_idx_q)
               3'd0:    begin cmd_addr = 8'h0F; cmd_data = 8'h00; end
               3'd1:    begin cmd_addr = 8'h09; cmd_data = 8'h00; end
               3'd2:    begin cmd_addr = 8'h0B; cmd_data = {5'd0, SCAN_LIMIT}; end
               3'd3:    begin cmd_addr = 8'h0A; cmd_data = {4'd0, intensity}; end
               default: begin cmd_addr = 8'h0C; cmd_data = 8'h01; end
            endcase
         end
         REFRESH: begin
            cmd_addr = {5'd0, row_q} + 8'd1;
            cmd_data = fb_rows[row_q];
         end
         INTENS: begin
            cmd_addr = 8'h0A;
            cmd_data = {4'd0, intensity};
         end
         default: begin
            cmd_addr = 8'h00;
            cmd_data = 8'h00;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         top_q      <= IDLE;
         cmd_q      <= GAP;
         init_idx_q <= '0;
         row_q      <= '0;
         cnt_q      <= '0;
         ilast_q    <= '0;
         str_q      <= 1'b0;
         irreg_q    <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         fd_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         top_q      <= top_d;
         cmd_q      <= cmd_d;
         init_idx_q <= init_idx_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         ilast_q    <= ilast_d;
         str_q      <= str_d;
         irreg_q    <= irreg_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         fd_q       <= fd_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      top_d      = top_q;
      cmd_d      = cmd_q;
      init_idx_d = init_idx_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      ilast_d    = ilast_q;
      str_d      = str_q;
      irreg_d    = irreg_q;
      data_d     = data_q;
      ready_d    = ready_q;
      fd_d       = 1'b0;
      err_d      = err_q;
      if (top_q == IDLE) begin
         str_d = 1'b0;
         if (start) begin
            top_d      = INIT;
            init_idx_d = '0;
            row_d      = '0;
            cmd_d      = GAP;
            cnt_d      = '0;
         end
      end else begin
         case (cmd_q)
            // GAP plus ISSUE keep str low for two cycles between words
            GAP: cmd_d = ISSUE;
            ISSUE: begin
               irreg_d = cmd_addr;
               data_d  = cmd_data;
               str_d   = 1'b1;
               cnt_d   = '0;
               cmd_d   = WAIT_HI;
               if (cmd_addr == 8'h0A) ilast_d = intensity;
            end
            WAIT_HI: begin
               if (busy) begin
                  cmd_d = WAIT_LO;
                  cnt_d = '0;
               end else if (cnt_q >= TO_LAST) begin
                  str_d = 1'b0;
                  err_d = 1'b1;
                  cmd_d = GAP;
                  cnt_d = '0;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + 13'd1;
               end
            end
            default: begin
               if (!busy) begin
                  str_d = 1'b0;
                  cmd_d = GAP;
                  if (top_q == REFRESH && row_q == 3'd7) fd_d = 1'b1;
                  if (!start) begin
                     top_d   = IDLE;
                     ready_d = 1'b0;
                  end else begin
                     case (top_q)
                        INIT: begin
                           if (init_idx_q == 3'd4) begin
                              top_d   = REFRESH;
                              ready_d = 1'b1;
                              row_d   = '0;
                           end else begin
                              init_idx_d = init_idx_q + 3'd1;
                           end
                        end
                        REFRESH: begin
                           if (row_q == 3'd7) begin
                              row_d = '0;
                              if (intensity != ilast_q) top_d = INTENS;
                           end else begin
                              row_d = row_q + 3'd1;
                           end
                        end
                        INTENS: begin
                           top_d = REFRESH;
                           row_d = '0;
                        end
                        default: top_d = IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign str        = str_q;
   assign IRreg      = irreg_q;
   assign data       = data_q;
   assign ready      = ready_q;
   assign frame_done = fd_q;
   assign err        = err_q;
endmodule

// File: doc/max7219_frame_ctrl.md
MAX7219_FRAME_CTRL -- requirements
Module: max7219_frame_ctrl

Interface
REQ-001 Parameter BUSY_TO, default 4096: sys_clk cycles allowed for busy to rise after str asserts.
REQ-002 Parameter SCAN_LIMIT, default 3'd7: value written to register 0x0B.
REQ-003 sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 _rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level; while high, the block leaves IDLE and runs init followed by continuous refresh; low stops the block after the current command.
REQ-006 intensity  in  4  requested brightness, value for register 0x0A.
REQ-007 wr_en  in  1  frame-buffer write strobe.
REQ-008 wr_row  in  3  frame-buffer row index, 0..7.
REQ-009 wr_data  in  8  row pixel data; bit7 = leftmost column.
REQ-010 busy  in  1  from the downstream SPI word writer; high while a 16-bit transfer is in progress.
REQ-011 str  out  1  transfer request to the writer.
REQ-012 IRreg  out  8  MAX7219 register address for the current transfer.
REQ-013 data  out  8  MAX7219 register data for the current transfer.
REQ-014 ready  out  1  high once init is complete and refresh is running.
REQ-015 frame_done  out  1  one-cycle pulse after digit 7 (register 0x08) completes.
REQ-016 err  out  1  sticky; set on a busy timeout; cleared only by reset.

Function
REQ-017 Frame buffer: 8x8 bits; on wr_en, row wr_row <= wr_data at the next edge; writes are accepted in every state.
REQ-018 Top FSM states: IDLE, INIT, REFRESH, INTENS.
- IDLE -> INIT when start = 1.
REQ-019 INIT issues five commands in order, as address/data pairs:
- 0x0F/0x00, 0x09/0x00, 0x0B/{5'd0,SCAN_LIMIT}, 0x0A/{4'd0,intensity}, 0x0C/0x01.
- Then ready <= 1 and the FSM enters REFRESH at row 0.
REQ-020 REFRESH issues address 0x01+r with data = buffer[r], for r = 0..7, then wraps to r = 0.
- frame_done pulses in the cycle the r = 7 command completes.
REQ-021 At each wrap to r = 0, if intensity differs from the last value written:
- enter INTENS and issue 0x0A/{4'd0,intensity};
- update the stored value;
- then resume at r = 0.
REQ-022 If start = 0 when a command completes, the FSM goes to IDLE with ready <= 0; a command in progress is never aborted.
REQ-023 Command handshake, per command, with sub-states ISSUE, WAIT_HI, WAIT_LO:
- ISSUE: latch IRreg/data, str <= 1.
- WAIT_HI: wait for busy = 1.
- WAIT_LO: wait for busy = 0, then str <= 0 in that same edge; command complete.
REQ-024 IRreg and data shall remain stable from ISSUE until str falls.
- A buffer write to the row being sent affects only the next frame.
REQ-025 After each command str shall stay low for at least 2 sys_clk cycles, so the writer's divider clears before the next ISSUE.
REQ-026 Busy timeout: if busy does not rise within BUSY_TO cycles in WAIT_HI:
- str <= 0 for 2 cycles, err <= 1;
- the same command is reissued;
- the counter is 13 bits and saturates.
REQ-027 busy high while the block is in IDLE or ISSUE is ignored.
REQ-028 Intensity is sampled only at ISSUE of a 0x0A command; changes mid-transfer do not affect the current word.

Reset
REQ-029 _rst low asynchronously sets:
- str = 0, IRreg = 0x00, data = 0x00, ready = 0, frame_done = 0, err = 0;
- FSM = IDLE, row counter = 0, init index = 0, timeout counter = 0;
- stored intensity = 0x0.
REQ-030 The frame buffer is cleared to all zeros by reset.
REQ-031 Reset mid-transfer drops str immediately; after release, the full init sequence repeats on start.

Verification
REQ-032 start = 1, intensity = 4'h8, writer model asserts busy 3 cycles after str for 40 cycles -> exact 5-command init sequence with 0x0A/0x08, then ready = 1.
REQ-033 Buffer rows loaded 0x81, 0x42, ..., 0x18 before start -> refresh emits 0x01/0x81 ... 0x08/0x18, frame_done pulses once per 8 rows, wraps to 0x01.
REQ-034 intensity changed 8 -> 15 mid-frame -> 0x0A/0x0F appears exactly once, between 0x08 and the next 0x01.
REQ-035 Writer model never asserts busy, BUSY_TO = 16 -> str falls after 16 cycles, err = 1, same IRreg/data are reissued.
REQ-036 wr_en to row 3 while row 3 is in WAIT_LO -> current data unchanged, new value sent in the next frame.
REQ-037 _rst pulsed during a REFRESH transfer -> str = 0 in the same cycle, all outputs at reset values, init re-runs from 0x0F.
